// File: rtl/ssd_scan_pkg.sv
// Shared types and constants for the ssd_scan multiplexed display controller.
package ssd_scan_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_e;

endpackage

// File: rtl/ssd_scan_if.sv
// Valid/ready handshake carrying one DIGITS-nibble display word into ssd_scan.
interface ssd_scan_if #(
    parameter int DIGITS = 4
);
    import ssd_scan_pkg::*;

    logic [NIB_W*DIGITS-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ssd_scan_timer.sv
// Per-slot cycle counter for ssd_scan: flags the end of the blank guard and of the whole slot.
module ssd_scan_timer #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic blank_done_o,
    output logic slot_done_o
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        if (clr_i || cnt_q == SLOT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blank_done_o = !clr_i && cnt_q == BLANK_LAST;
    assign slot_done_o  = !clr_i && cnt_q == SLOT_LAST;

endmodule

// File: rtl/ssd_scan.sv
// Time-multiplexed 7-segment scan controller with double-buffered input word.
// Define SSD_SCAN_LZB_EN to blank leading-zero digits (digit 0 always lit).
module ssd_scan
    import ssd_scan_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    ssd_scan_if.slave         in_if,
    output logic [NIB_W-1:0]  nibble,
    output logic [DIGITS-1:0] dig_en_n,
    output logic              frame_tick
);

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef logic [DIGITS-1:0][NIB_W-1:0] word_t;

    state_e             state_q;
    logic [IW-1:0]      idx_q;
    logic [IW-1:0]      idx_nxt;
    word_t              display_q;
    word_t              display_d;
    word_t              pend_q;
    logic               pend_full_q;
    logic               pend_full_d;
    logic [NIB_W-1:0]   nibble_q;
    logic [DIGITS-1:0]  dig_en_n_q;
    logic               frame_tick_q;

    logic               timer_clr;
    logic               blank_done;
    logic               slot_done;
    logic               boundary;
    logic               accept;
    logic               lit;
    logic [DIGITS-1:0]  onehot;

    assign timer_clr = !en || state_q == IDLE;

    ssd_scan_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (timer_clr),
        .blank_done_o (blank_done),
        .slot_done_o  (slot_done)
    );

    // Boundary swap uses the pending state before this edge, so a word accepted
    // on a boundary cycle waits for the next frame.
    always_comb begin
        idx_nxt     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        boundary    = en && ((state_q == IDLE) ||
                             (state_q == SHOW && slot_done && idx_q == IDX_LAST));
        accept      = in_if.in_valid && !pend_full_q;
        display_d   = display_q;
        pend_full_d = pend_full_q;
        if (boundary && pend_full_q) begin
            display_d   = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_full_d = 1'b1;
        end
    end

    assign in_if.in_ready = !pend_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            display_q   <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            display_q   <= display_d;
            pend_full_q <= pend_full_d;
            if (accept) begin
                pend_q <= in_if.in_data;
            end
        end
    end

`ifdef SSD_SCAN_LZB_EN
    logic [DIGITS-1:0] nz_above;
    logic              nz_acc;
`endif

    always_comb begin
        onehot        = '0;
        onehot[idx_q] = 1'b1;
`ifdef SSD_SCAN_LZB_EN
        nz_acc   = 1'b0;
        nz_above = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nz_acc                   = nz_acc | (|display_q[DIGITS-1-k]);
            nz_above[DIGITS-1-k]     = nz_acc;
        end
        lit = (idx_q == '0) || nz_above[idx_q];
`else
        lit = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            nibble_q     <= '0;
            dig_en_n_q   <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= boundary;
            if (!en) begin
                state_q    <= IDLE;
                idx_q      <= '0;
                dig_en_n_q <= '1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q  <= BLANK;
                        idx_q    <= '0;
                        nibble_q <= display_d[0];
                    end
                    BLANK: begin
                        if (blank_done) begin
                            state_q    <= SHOW;
                            dig_en_n_q <= lit ? ~onehot : '1;
                        end
                    end
                    SHOW: begin
                        if (slot_done) begin
                            state_q    <= BLANK;
                            idx_q      <= idx_nxt;
                            dig_en_n_q <= '1;
                            nibble_q   <= display_d[idx_nxt];
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign nibble     = nibble_q;
    assign dig_en_n   = dig_en_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan.sv
// Scoreboard bench for ssd_scan (DIGITS=4, PRESCALE=8, BLANK_CYCLES=2); honours SSD_SCAN_LZB_EN.
module tb_ssd_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] nibble;
    logic [3:0] dig_en_n;
    logic       frame_tick;

    ssd_scan_if #(.DIGITS(4)) bus ();

    ssd_scan #(
        .DIGITS       (4),
        .PRESCALE     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_if      (bus),
        .nibble     (nibble),
        .dig_en_n   (dig_en_n),
        .frame_tick (frame_tick)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en_n;
        logic [3:0]  nib;
        int unsigned gap;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state: what the DUT should hold, advanced once per cycle.
    logic        rst_p = 1'b1;
    logic        en_p = 1'b0;
    logic        xfer_p = 1'b0;
    logic [15:0] data_p = '0;
    logic        pend_full_m = 1'b0;
    logic [15:0] pend_m = '0;
    logic [15:0] disp_m = '0;
    int unsigned run_len = 0;
    int unsigned run_gap = 0;
    int unsigned gap_cnt = 0;
    int unsigned tick_cnt = 0;
    int unsigned skip_carry = 0;
    logic        have_tick = 1'b0;
    logic [3:0]  run_pat = '0;
    logic [3:0]  run_nib = '0;

    logic [3:0]  obs_dig;
    logic [3:0]  obs_nib;
    logic        obs_rdy;
    logic        obs_tick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] w);
        exp_t        e;
        logic [15:0] rest;
        logic        show;
        for (int i = 0; i < 4; i++) begin
            rest = w >> (4 * i);
            show = 1'b1;
`ifdef SSD_SCAN_LZB_EN
            if (i > 0 && rest == 16'h0) show = 1'b0;
`endif
            if (show) begin
                e.en_n = 4'hF ^ (4'h1 << i);
                e.nib  = rest[3:0];
                e.gap  = 2 + 8 * skip_carry;
                sb.push_back(e);
                skip_carry = 0;
            end else begin
                skip_carry++;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        obs_dig  = dig_en_n;
        obs_nib  = nibble;
        obs_rdy  = bus.in_ready;
        obs_tick = frame_tick;
        if (rst_p) begin
            pend_full_m = 1'b0;
            pend_m      = '0;
            disp_m      = '0;
            sb.delete();
            run_len     = 0;
            gap_cnt     = 0;
            tick_cnt    = 0;
            have_tick   = 1'b0;
            skip_carry  = 0;
        end else begin
            if (obs_dig != 4'hF) begin
                if (run_len == 0) begin
                    run_pat = obs_dig;
                    run_nib = obs_nib;
                    run_gap = gap_cnt;
                    chk("one_hot", 32'($countones(~obs_dig)), 32'd1);
                end else begin
                    chk("run_stable", 32'({obs_dig, obs_nib}), 32'({run_pat, run_nib}));
                end
                run_len++;
            end else begin
                if (run_len > 0) begin
                    if (sb.size() == 0) begin
                        chk("sb_depth", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("run_digit", 32'(run_pat), 32'(e.en_n));
                        chk("run_nibble", 32'(run_nib), 32'(e.nib));
                        chk("run_gap", run_gap, e.gap);
                        if (en_p) chk("run_len", run_len, 32'd6);
                    end
                    run_len = 0;
                    gap_cnt = 0;
                end
                if (!en_p) begin
                    sb.delete();
                    gap_cnt    = 0;
                    skip_carry = 0;
                    have_tick  = 1'b0;
                end else begin
                    gap_cnt++;
                end
            end
            tick_cnt++;
            if (obs_tick) begin
                if (have_tick) chk("frame_period", tick_cnt, 32'd32);
                have_tick = 1'b1;
                tick_cnt  = 0;
                if (pend_full_m) begin
                    disp_m      = pend_m;
                    pend_full_m = 1'b0;
                end
                push_frame(disp_m);
            end
            if (xfer_p) begin
                pend_m      = data_p;
                pend_full_m = 1'b1;
            end
        end
        chk("in_ready", 32'(obs_rdy), 32'(!pend_full_m));
        xfer_p = bus.in_valid && !pend_full_m && !rst;
        data_p = bus.in_data;
        rst_p  = rst;
        en_p   = en;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        logic done;
        done         = 1'b0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            step();
            if (obs_rdy) done = 1'b1;
        end
        if (!done) chk("send_ready", 32'(obs_rdy), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ticks(input int unsigned n);
        int unsigned seen;
        seen = 0;
        for (int k = 0; k < 40 * n && seen < n; k++) begin
            step();
            if (obs_tick) seen++;
        end
        if (seen < n) chk("tick_wait", seen, n);
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        repeat (3) step();
        chk("rst_dig_en_n", 32'(obs_dig), 32'hF);
        chk("rst_nibble", 32'(obs_nib), 32'h0);
        chk("rst_in_ready", 32'(obs_rdy), 32'h1);
        chk("rst_frame_tick", 32'(obs_tick), 32'h0);
        rst = 1'b0;

        send(16'h1234);
        en = 1'b1;
        wait_ticks(3);

        send(16'hAAAA);
        send(16'hBBBB);
        wait_ticks(2);

        send(16'h5678);
        for (int k = 0; k < 64 && obs_dig != 4'b1011; k++) step();
        if (obs_dig != 4'b1011) chk("find_digit2", 32'(obs_dig), 32'hB);
        en = 1'b0;
        step();
        step();
        chk("drop_dark", 32'(obs_dig), 32'hF);
        repeat (3) step();
        chk("hold_pending", 32'(obs_rdy), 32'h0);
        en = 1'b1;
        step();
        step();
        chk("restart_tick", 32'(obs_tick), 32'h1);
        step();
        chk("restart_blank", 32'(obs_dig), 32'hF);
        step();
        chk("restart_digit0", 32'(obs_dig), 32'hE);
        chk("restart_nibble", 32'(obs_nib), 32'h8);

        send(16'h0050);
        wait_ticks(3);

        send(16'h9999);
        for (int k = 0; k < 64 && obs_dig == 4'hF; k++) step();
        if (obs_dig == 4'hF) chk("find_lit", 32'(obs_dig), 32'hE);
        rst = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b0;
        step();
        chk("rst2_dig_en_n", 32'(obs_dig), 32'hF);
        chk("rst2_nibble", 32'(obs_nib), 32'h0);
        chk("rst2_in_ready", 32'(obs_rdy), 32'h1);
        chk("rst2_frame_tick", 32'(obs_tick), 32'h0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
